// File: rtl/pipelined_addsub_pkg.sv
// Shared ALU constants for the pipelined adder/subtractor.
// Mode encodings, default width and the slice-geometry check.
package pipelined_addsub_pkg;

    localparam logic ADD       = 1'b0;
    localparam logic SUB       = 1'b1;
    localparam int   DEFAULT_N = 8;

    // The carry chain must split into equal, non-empty ripple slices.
    function automatic bit stages_ok(input int n, input int stages);
        return (stages >= 1) && (stages <= n) && ((n % stages) == 0);
    endfunction

endpackage

// File: rtl/rca_slice.sv
// W-bit ripple-carry slice; also exposes the carry into its MSB for overflow.
// Latency: combinational.
// Backpressure: none, pure datapath.
module rca_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);

    always_comb begin : ripple
        logic [W:0] c;
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout     = c[W];
        c_msb_in = c[W-1];
    end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined N-bit add/sub with flags; carry chain cut into STAGES registered slices.
// Latency: STAGES cycles from input transfer to out_valid.
// Backpressure: one global advance enable; a stalled output freezes every stage and drops in_ready.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int N      = DEFAULT_N,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam int W = N / STAGES;

    if (!stages_ok(N, STAGES)) begin : g_cfg_err
        $error("pipelined_addsub: N=%0d cannot be cut into %0d equal slices", N, STAGES);
    end

    logic         adv;
    logic [N-1:0] b_eff;
    logic         cin_eff;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Subtract as a + ~b + !cin so the chain carry doubles as "no borrow".
    assign b_eff   = (sub == ADD) ? b : ~b;
    assign cin_eff = (sub == SUB) ? ~cin : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO  = k * W;
        localparam int REM = N - LO;

        logic [REM-1:0]  a_cur;
        logic [REM-1:0]  b_cur;
        logic            c_cur;
        logic            v_cur;
        logic [LO+W-1:0] s_next;
        logic [W-1:0]    s_w;
        logic            c_w;
        logic            c_msb;
        logic [LO+W-1:0] s_q;
        logic            c_q;
        logic            v_q;

        if (k == 0) begin : g_first
            assign a_cur  = a;
            assign b_cur  = b_eff;
            assign c_cur  = cin_eff;
            assign v_cur  = in_valid;
            assign s_next = s_w;
        end else begin : g_next
            assign a_cur  = g_stg[k-1].g_fwd.a_q;
            assign b_cur  = g_stg[k-1].g_fwd.b_q;
            assign c_cur  = g_stg[k-1].c_q;
            assign v_cur  = g_stg[k-1].v_q;
            assign s_next = {s_w, g_stg[k-1].s_q};
        end

        rca_slice #(.W(W)) u_slice (
            .a        (a_cur[W-1:0]),
            .b        (b_cur[W-1:0]),
            .cin      (c_cur),
            .s        (s_w),
            .cout     (c_w),
            .c_msb_in (c_msb)
        );

        // Data only loads with a real operation, so bubbles leave the last result in place.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                s_q <= '0;
                c_q <= 1'b0;
            end else if (adv) begin
                v_q <= v_cur;
                if (v_cur) begin
                    s_q <= s_next;
                    c_q <= c_w;
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [REM-W-1:0] a_q;
            logic [REM-W-1:0] b_q;
            logic             unused_c_msb;

            assign unused_c_msb = c_msb;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv && v_cur) begin
                    a_q <= a_cur[REM-1:W];
                    b_q <= b_cur[REM-1:W];
                end
            end
        end else begin : g_last
            logic ovf_q;
            logic zero_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv && v_cur) begin
                    ovf_q  <= c_msb ^ c_w;
                    zero_q <= (s_next == '0);
                end
            end
        end
    end

    assign out_valid = g_stg[STAGES-1].v_q;
    assign sum       = g_stg[STAGES-1].s_q;
    assign cout      = g_stg[STAGES-1].c_q;
    assign ovf       = g_stg[STAGES-1].g_last.ovf_q;
    assign zero      = g_stg[STAGES-1].g_last.zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub at N=8 with STAGES = 1, 2, 4, 8 side by side on shared inputs.
module tb_pipelined_addsub;
    import pipelined_addsub_pkg::*;

    localparam int NI = 4;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
    } op_t;

    typedef struct {
        op_t        op;
        logic [7:0] s;
        logic       co;
        logic       ov;
        logic       z;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;

    logic       in_ready_w  [NI];
    logic       out_valid_w [NI];
    logic [7:0] sum_w       [NI];
    logic       cout_w      [NI];
    logic       ovf_w       [NI];
    logic       zero_w      [NI];

    int vectors;
    int miscompares;

    logic [10:0] ring [NI][64];
    int          head [NI];
    int          tail [NI];
    int          dcnt [NI];
    logic        stl  [NI];
    logic [10:0] snap [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        pipelined_addsub #(.N(8), .STAGES(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .sub       (sub),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .sum       (sum_w[g]),
            .cout      (cout_w[g]),
            .ovf       (ovf_w[g]),
            .zero      (zero_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] obs(input int i);
        return {sum_w[i], cout_w[i], ovf_w[i], zero_w[i]};
    endfunction

    // Reference: plain integer arithmetic, unsigned for carry/borrow, signed for overflow.
    function automatic logic [10:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                          input logic mc, input logic ms);
        int ua, ub, sa, sb, c, r, rs;
        logic [7:0] s;
        logic co, ov;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        c  = mc ? 1 : 0;
        if (ms == ADD) begin
            r  = ua + ub + c;
            co = (r > 255);
            rs = sa + sb + c;
        end else begin
            r  = ua - ub - c;
            co = (ua >= ub + c);
            rs = sa - sb - c;
        end
        s  = 8'(r);
        ov = (rs > 127) || (rs < -128);
        return {s, co, ov, (s == 8'd0)};
    endfunction

    function automatic vec_t mkv(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                                 input logic vs, input logic [7:0] es, input logic eco,
                                 input logic eov, input logic ez);
        vec_t v;
        v.op = '{a: va, b: vb, cin: vc, sub: vs};
        v.s  = es;
        v.co = eco;
        v.ov = eov;
        v.z  = ez;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_op(input op_t op);
        a   = op.a;
        b   = op.b;
        cin = op.cin;
        sub = op.sub;
    endtask

    // Sample after inputs settle; update per-instance scoreboards.
    task automatic monitor_cycle();
        #1;
        for (int i = 0; i < NI; i++) begin
            if (stl[i])
                check($sformatf("rnd_hold_s%0d", 1 << i), 32'({out_valid_w[i], obs(i)}),
                      32'({1'b1, snap[i]}));
            if (in_valid && in_ready_w[i]) begin
                ring[i][tail[i] % 64] = model(a, b, cin, sub);
                tail[i]++;
            end
            if (out_valid_w[i] && out_ready) begin
                if (head[i] == tail[i]) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rnd_spurious_s%0d: got result 0x%0h, expected none", 1 << i, obs(i));
                end else begin
                    check($sformatf("rnd_result_s%0d", 1 << i), 32'(obs(i)),
                          32'(ring[i][head[i] % 64]));
                    head[i]++;
                    dcnt[i]++;
                end
            end
            stl[i]  = out_valid_w[i] && !out_ready;
            snap[i] = obs(i);
        end
    endtask

    function automatic bit all_done();
        for (int i = 0; i < NI; i++)
            if (dcnt[i] < 1000) return 1'b0;
        return 1'b1;
    endfunction

    vec_t tbl [10];
    op_t  bp_ops [4];

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        a = 8'd0; b = 8'd0; cin = 1'b0; sub = ADD;

        tbl[0] = mkv(8'd100,  8'd27,   1'b0, ADD, 8'd127,  1'b0, 1'b0, 1'b0);
        tbl[1] = mkv(8'd127,  8'd1,    1'b0, ADD, 8'h80,   1'b0, 1'b1, 1'b0);
        tbl[2] = mkv(8'hFF,   8'h01,   1'b0, ADD, 8'h00,   1'b1, 1'b0, 1'b1);
        tbl[3] = mkv(8'd5,    8'd7,    1'b0, SUB, 8'hFE,   1'b0, 1'b0, 1'b0);
        tbl[4] = mkv(8'h80,   8'h01,   1'b0, SUB, 8'h7F,   1'b1, 1'b1, 1'b0);
        tbl[5] = mkv(8'd9,    8'd4,    1'b1, SUB, 8'd4,    1'b1, 1'b0, 1'b0);
        tbl[6] = mkv(8'h7F,   8'h00,   1'b1, ADD, 8'h80,   1'b0, 1'b1, 1'b0);
        tbl[7] = mkv(8'h33,   8'h33,   1'b0, SUB, 8'h00,   1'b1, 1'b0, 1'b1);
        tbl[8] = mkv(8'h00,   8'h00,   1'b1, SUB, 8'hFF,   1'b0, 1'b0, 1'b0);
        tbl[9] = mkv(8'h80,   8'h80,   1'b0, ADD, 8'h00,   1'b1, 1'b1, 1'b1);

        bp_ops[0] = '{a: 8'd10,  b: 8'd20,  cin: 1'b0, sub: ADD};
        bp_ops[1] = '{a: 8'd200, b: 8'd100, cin: 1'b1, sub: ADD};
        bp_ops[2] = '{a: 8'd50,  b: 8'd60,  cin: 1'b0, sub: SUB};
        bp_ops[3] = '{a: 8'd1,   b: 8'd1,   cin: 1'b0, sub: SUB};

        // Reset state
        #12;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_out_valid_s%0d", 1 << i), 32'(out_valid_w[i]), 32'd0);
            check($sformatf("rst_outputs_s%0d", 1 << i), 32'(obs(i)), 32'd0);
            check($sformatf("rst_in_ready_s%0d", 1 << i), 32'(in_ready_w[i]), 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors: result appears on exactly the STAGES-th cycle for every instance.
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            drive_op(tbl[v].op);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1;
            check($sformatf("vec%0d_in_ready", v), 32'(in_ready_w[1]), 32'd1);
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                in_valid = 1'b0;
                #1;
                for (int i = 0; i < NI; i++) begin
                    check($sformatf("vec%0d_s%0d_valid_c%0d", v, 1 << i, c),
                          32'(out_valid_w[i]), 32'(c == (1 << i)));
                    if (c == (1 << i))
                        check($sformatf("vec%0d_s%0d_result", v, 1 << i), 32'(obs(i)),
                              32'({tbl[v].s, tbl[v].co, tbl[v].ov, tbl[v].z}));
                end
            end
        end

        // Backpressure on STAGES=2: 4 back-to-back ops, 3-cycle stall after first result.
        begin
            int sent, got, stall_left;
            bit seen, stalled;
            logic [10:0] hold_v;
            sent = 0; got = 0; stall_left = 0; seen = 0; stalled = 0; hold_v = '0;
            for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
                @(negedge clk);
                if (stalled)
                    check("bp_hold", 32'({out_valid_w[1], obs(1)}), 32'({1'b1, hold_v}));
                if (out_valid_w[1] && !seen) begin
                    seen       = 1'b1;
                    stall_left = 3;
                end
                out_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
                in_valid = (sent < 4);
                if (sent < 4) drive_op(bp_ops[sent]);
                #1;
                if (!out_ready)
                    check("bp_in_ready_low", 32'(in_ready_w[1]), 32'd0);
                if (in_valid && in_ready_w[1]) sent++;
                if (out_valid_w[1] && out_ready) begin
                    check($sformatf("bp_order%0d", got), 32'(obs(1)),
                          32'(model(bp_ops[got].a, bp_ops[got].b, bp_ops[got].cin, bp_ops[got].sub)));
                    got++;
                end
                stalled = out_valid_w[1] && !out_ready;
                hold_v  = obs(1);
            end
            check("bp_delivered", 32'(got), 32'd4);
            check("bp_accepted", 32'(sent), 32'd4);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                #1;
                check("bp_no_duplicate", 32'(out_valid_w[1]), 32'd0);
            end
        end

        // Reset with two operations in flight.
        for (int c = 0; c < 10; c++) @(negedge clk);
        drive_op('{a: 8'h11, b: 8'h22, cin: 1'b0, sub: ADD});
        in_valid = 1'b1;
        @(negedge clk);
        drive_op('{a: 8'h40, b: 8'h01, cin: 1'b0, sub: ADD});
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("arst_out_valid_s%0d", 1 << i), 32'(out_valid_w[i]), 32'd0);
            check($sformatf("arst_outputs_s%0d", 1 << i), 32'(obs(i)), 32'd0);
            check($sformatf("arst_in_ready_s%0d", 1 << i), 32'(in_ready_w[i]), 32'd1);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < NI; i++)
                check($sformatf("arst_flushed_s%0d", 1 << i), 32'(out_valid_w[i]), 32'd0);
        end
        @(negedge clk);
        drive_op('{a: 8'd3, b: 8'd4, cin: 1'b0, sub: ADD});
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("arst_new_op_c1", 32'(out_valid_w[1]), 32'd0);
        @(negedge clk);
        #1;
        check("arst_new_op_valid", 32'(out_valid_w[1]), 32'd1);
        check("arst_new_op_result", 32'(obs(1)), 32'({8'd7, 1'b0, 1'b0, 1'b0}));

        // Randomised traffic against the scoreboard on all four configurations.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NI; i++) begin
            head[i] = 0; tail[i] = 0; dcnt[i] = 0; stl[i] = 1'b0; snap[i] = '0;
        end
        begin
            int cyc;
            cyc = 0;
            while (cyc < 12000 && !all_done()) begin
                @(negedge clk);
                in_valid  = ($urandom_range(0, 9) < 7);
                a         = 8'($urandom);
                b         = 8'($urandom);
                cin       = 1'($urandom);
                sub       = 1'($urandom);
                out_ready = ($urandom_range(0, 9) < 7);
                monitor_cycle();
                cyc++;
            end
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                in_valid  = 1'b0;
                out_ready = 1'b1;
                monitor_cycle();
            end
        end
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rnd_enough_ops_s%0d", 1 << i), 32'(dcnt[i] >= 1000), 32'd1);
            check($sformatf("rnd_drained_s%0d", 1 << i), 32'(tail[i] - head[i]), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
